// File: rtl/dcache_lite.sv
// Direct-mapped, write-through, write-allocate data cache with one word per frame.
// Read hits complete in zero cycles; misses and writes go to RAM and complete on dwait=0.
module dcache_lite #(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic [31:0] hit_count,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        dwait
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {IDLE, RMISS, WRITE, FLUSHED} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SETS-1:0]    r_valid;
    logic [TAG_W-1:0]   r_tag  [SETS];
    logic [31:0]        r_data [SETS];
    logic [31:0]        r_hit_count;

    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [31:0]        w_word_addr;
    logic               w_hit;
    logic               w_fill;
    logic [31:0]        w_fill_data;
    logic               w_hit_inc;
    logic               w_unused;

    assign w_idx       = dmemaddr[IDX_W+1:2];
    assign w_tag       = dmemaddr[31:IDX_W+2];
    assign w_word_addr = {dmemaddr[31:2], 2'b00};
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_unused    = ^dmemaddr[1:0];
    assign hit_count   = r_hit_count;

    always_comb begin
        w_state_next = r_state;
        dhit         = 1'b0;
        dmemload     = '0;
        flushed      = 1'b0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        w_fill       = 1'b0;
        w_fill_data  = '0;
        w_hit_inc    = 1'b0;
        unique case (r_state)
            IDLE: begin
                // halt outranks any pending request: nothing new is accepted once halted
                if (halt) begin
                    w_state_next = FLUSHED;
                end else if (dmemWEN) begin
                    w_state_next = WRITE;
                end else if (dmemREN) begin
                    if (w_hit) begin
                        dhit      = 1'b1;
                        dmemload  = r_data[w_idx];
                        w_hit_inc = 1'b1;
                    end else begin
                        w_state_next = RMISS;
                    end
                end
            end
            RMISS: begin
                ramREN  = 1'b1;
                ramaddr = w_word_addr;
                if (!dwait) begin
                    w_fill       = 1'b1;
                    w_fill_data  = ramload;
                    dhit         = dmemREN;
                    dmemload     = ramload;
                    w_state_next = halt ? FLUSHED : IDLE;
                end
            end
            WRITE: begin
                ramWEN   = 1'b1;
                ramaddr  = w_word_addr;
                ramstore = dmemstore;
                if (!dwait) begin
                    w_fill       = 1'b1;
                    w_fill_data  = dmemstore;
                    dhit         = dmemWEN;
                    w_state_next = halt ? FLUSHED : IDLE;
                end
            end
            FLUSHED: begin
                flushed = 1'b1;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_hit_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_fill) begin
                r_valid[w_idx] <= 1'b1;
            end
            if (w_hit_inc) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
        end
    end

    // Tag/data need no reset; a reset abandons any fill in progress
    always_ff @(posedge CLK) begin
        if (!RST && w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= w_fill_data;
        end
    end

endmodule

// File: doc/dcache_lite.md
DCACHE_LITE -- requirements
Module: dcache_lite

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 The ports SHALL be as follows, clock and reset first:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous active-high reset.
- dmemREN  in  1  datapath read request, held until dhit.
- dmemWEN  in  1  datapath write request, held until dhit.
- dmemaddr  in  32  word address; bits [1:0] ignored.
- dmemstore  in  32  write data.
- halt  in  1  datapath halted; drain, then report flushed.
- dhit  out  1  request complete this cycle.
- dmemload  out  32  read data, valid when dhit and dmemREN.
- flushed  out  1  cache drained after halt.
- hit_count  out  32  number of cache-hit reads completed.
- ramREN  out  1  RAM read request.
- ramWEN  out  1  RAM write request.
- ramaddr  out  32  RAM word address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data, valid when dwait=0.
- dwait  in  1  RAM busy; 0 marks the completing cycle of the RAM access.
REQ-003 Parameters SHALL be:
- SETS, default 16, number of direct-mapped frames (power of 2).
- Index SHALL be dmemaddr[5:2] and tag SHALL be dmemaddr[31:6] at the default size.

Function
REQ-004 Each frame SHALL hold valid (1b), tag and data (32b); the cache is write-through, write-allocate, one word per frame.
REQ-005 The FSM SHALL have the states IDLE, RMISS, WRITE and FLUSHED.
REQ-006 In IDLE, when dmemWEN=1, the next state SHALL be WRITE; WEN has priority if REN and WEN are both high.
REQ-007 In IDLE, for a read hit (dmemREN=1, WEN=0, valid and tag match), dhit=1 and dmemload=frame data SHALL be driven combinationally in the same cycle (zero latency), and hit_count SHALL increment at the next edge.
REQ-008 In IDLE, for a read miss, the next state SHALL be RMISS; dhit SHALL be 0.
REQ-009 In RMISS, ramREN=1 and ramaddr={dmemaddr[31:2],2'b00} SHALL be driven.
- While dwait=1, the state SHALL be held.
- When dwait=0, the block SHALL write the frame (valid=1, tag, data=ramload), drive dhit=dmemREN and dmemload=ramload, and return to IDLE.
- hit_count SHALL NOT change on a miss.
REQ-010 In WRITE, ramWEN=1, ramaddr as in REQ-009 and ramstore=dmemstore SHALL be driven.
- When dwait=0, the block SHALL write the frame (valid=1, tag, data=dmemstore), drive dhit=dmemWEN and return to IDLE.
REQ-011 If the request drops mid-miss or mid-write, the RAM access SHALL still complete and fill the frame; dhit SHALL be 0.
REQ-012 ramREN and ramWEN SHALL never be high in the same cycle; both SHALL be 0 in IDLE and FLUSHED.
REQ-013 When halt=1 in IDLE, the next state SHALL be FLUSHED, with no new requests accepted.
- An in-flight RMISS or WRITE SHALL finish first, then enter FLUSHED.
- FLUSHED SHALL drive flushed=1, hold until reset, and assert dhit=0 and no RAM requests.
REQ-014 hit_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-015 Outside the cases in REQ-007 and REQ-009, dmemload SHALL be 0.

Reset
REQ-016 When RST=1 at a posedge, the block SHALL set state=IDLE, clear all valid bits, and set hit_count=0, flushed=0, dhit=0, ramREN=0 and ramWEN=0. Tag and data contents need not be cleared.
REQ-017 Reset during RMISS or WRITE SHALL abandon the access: ramREN and ramWEN SHALL be 0 in the following cycle, and no frame update SHALL occur.

Verification
REQ-018 Cold read: REN, addr=0x40, dwait=1 for 2 cycles then 0 with ramload=0xDEADBEEF -> ramREN high 3 cycles, dhit in the 3rd with dmemload=0xDEADBEEF, hit_count=0.
REQ-019 Re-read: REN, addr=0x40 in IDLE -> dhit same cycle, dmemload=0xDEADBEEF, no ramREN, hit_count=1.
REQ-020 Conflict: write 0x1234 to 0x80 (same index as 0x40), then read 0x40 -> ramWEN with ramaddr=0x80 and ramstore=0x1234; the later read misses (ramREN, ramaddr=0x40).
REQ-021 REN and WEN both high, addr=0x8 -> WRITE path taken, ramREN never asserted.
REQ-022 Halt during RMISS -> miss completes with dhit, flushed=1 the following cycle, later REN ignored (dhit=0, ramREN=0).
REQ-023 RST mid-RMISS, then read the same address -> ramREN=0 next cycle; the later read misses again (valid cleared), hit_count=0.
